// File: rtl/nios_mtl_sysid_ext.sv
// rtl/nios_mtl_sysid_ext.sv - system-ID peripheral with uptime counter, scratch, ctrl/status and caps
module nios_mtl_sysid_ext #(
  parameter logic [31:0] ID_VALUE    = 32'h57164B78,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int          CNT_W       = 64,
  parameter int          ADDR_W      = 3,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(6);
  localparam logic [31:0]       CAPS_WORD = {16'h0001, 8'(CNT_W), 8'(ADDR_W)};

  logic [CNT_W-1:0]  uptime;
  logic [CNT_W-33:0] hi_snap;
  logic [31:0]       scratch;
  logic              run;
  logic              ovf;

  logic [31:0] hi_ext;
  logic [31:0] rd_mux;
  logic        ctrl_wr;
  logic        clear;
  logic        wrap;
  logic        lo_read;

  assign ctrl_wr = write && (address == A_CTRL) && byteenable[0];
  assign clear   = ctrl_wr && writedata[1];
  assign wrap    = run && (uptime == '1);
  assign lo_read = read && (address == A_UP_LO);

  always_comb begin
    hi_ext = '0;
    hi_ext[CNT_W-33:0] = hi_snap;
  end

  // Read mux sees only current state, so a same-cycle write is never visible to the read.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_ID:      rd_mux = ID_VALUE;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_UP_LO:   rd_mux = uptime[31:0];
      A_UP_HI:   rd_mux = hi_ext;
      A_SCRATCH: rd_mux = scratch;
      A_CTRL:    rd_mux = {29'b0, ovf, 1'b0, run};
      A_CAPS:    rd_mux = CAPS_WORD;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      uptime        <= '0;
      hi_snap       <= '0;
      scratch       <= SCRATCH_RST;
      run           <= 1'b1;
      ovf           <= 1'b0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? rd_mux : '0;

      // Snapshot the pre-increment high bits so LO/HI form one coherent value.
      if (lo_read)
        hi_snap <= uptime[CNT_W-1:32];

      if (clear)
        uptime <= '0;
      else if (run)
        uptime <= uptime + CNT_W'(1);

      if (wrap)
        ovf <= 1'b1;
      else if (ctrl_wr && writedata[2])
        ovf <= 1'b0;

      if (ctrl_wr)
        run <= writedata[0];

      for (int i = 0; i < 4; i++) begin
        if (write && (address == A_SCRATCH) && byteenable[i])
          scratch[8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_nios_mtl_sysid_ext.sv
// tb/tb_nios_mtl_sysid_ext.sv - directed self-checking bench for nios_mtl_sysid_ext
module tb_nios_mtl_sysid_ext;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rd64, rd33;
  logic        rdv64, rdv33;

  int checks = 0;
  int errors = 0;

  nios_mtl_sysid_ext dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd64), .readdatavalid(rdv64)
  );

  nios_mtl_sysid_ext #(.CNT_W(33)) dut33 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd33), .readdatavalid(rdv33)
  );

  always #5 clock = ~clock;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(posedge clock);
    #1;
    write = 1'b0; byteenable = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d64, output logic v64,
                          output logic [31:0] d33, output logic v33);
    @(negedge clock);
    address = a; read = 1'b1;
    @(posedge clock);
    #1;
    d64 = rd64; v64 = rdv64; d33 = rd33; v33 = rdv33;
    read = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (rdv64 !== 1'b0 || rd64 !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h required valid=0 data=0", rdv64, rd64);
    end
  endtask

  task automatic test_id_caps;
    logic [31:0] exp_d [3];
    logic [2:0]  addrs [3];
    addrs[0] = 3'd0; addrs[1] = 3'd1; addrs[2] = 3'd6;
    exp_d[0] = 32'h57164B78; exp_d[1] = 32'h0; exp_d[2] = 32'h00014003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      address = addrs[i]; read = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (rdv64 !== 1'b1 || rd64 !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: valid=%b data=%h required valid=1 data=%h", i, rdv64, rd64, exp_d[i]);
      end
    end
    read = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (rdv64 !== 1'b0 || rd64 !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_b2b: valid=%b data=%h required 0/0", rdv64, rd64);
    end
  endtask

  task automatic test_scratch;
    logic [31:0] d, d3; logic v, v3;
    bus_write(3'd4, 32'hDEADBEEF, 4'b1111);
    bus_write(3'd4, 32'h000000AA, 4'b0001);
    bus_read(3'd4, d, v, d3, v3);
    checks++;
    if (d !== 32'hDEADBEAA || v !== 1'b1) begin
      errors++;
      $display("FAIL scratch_lanes: data=%h required DEADBEAA", d);
    end
    bus_write(3'd0, 32'h12345678, 4'b1111);
    bus_write(3'd7, 32'h12345678, 4'b1111);
    bus_read(3'd0, d, v, d3, v3);
    checks++;
    if (d !== 32'h57164B78) begin
      errors++;
      $display("FAIL ro_id_write: data=%h required 57164B78", d);
    end
    bus_read(3'd7, d, v, d3, v3);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL addr7: data=%h valid=%b required 0/1", d, v);
    end
    // read and write to scratch in one cycle: read sees old value
    @(negedge clock);
    address = 3'd4; read = 1'b1; write = 1'b1; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0; byteenable = '0;
    checks++;
    if (rd64 !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL rw_same_cycle: data=%h required DEADBEAA", rd64);
    end
    bus_read(3'd4, d, v, d3, v3);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rw_after: data=%h required CAFEF00D", d);
    end
  endtask

  task automatic test_hi_snapshot;
    logic [31:0] d, d3; logic v, v3;
    bus_write(3'd5, 32'h0, 4'b0001);
    @(negedge clock);
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.uptime;
    bus_write(3'd5, 32'h1, 4'b0001);
    bus_read(3'd2, d, v, d3, v3);
    checks++;
    if (d !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL lo_pre_inc: data=%h required FFFFFFFF", d);
    end
    repeat (5) @(posedge clock);
    bus_read(3'd3, d, v, d3, v3);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL hi_is_snapshot: data=%h required 00000000", d);
    end
    bus_read(3'd2, d, v, d3, v3);
    bus_read(3'd3, d, v, d3, v3);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL hi_after_relatch: data=%h required 00000001", d);
    end
  endtask

  task automatic test_wrap33;
    logic [31:0] d, d3; logic v, v3;
    bus_read(3'd6, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h00012103) begin
      errors++;
      $display("FAIL caps33: data=%h required 00012103", d3);
    end
    bus_write(3'd5, 32'h0, 4'b0001);
    @(negedge clock);
    force dut33.uptime = 33'h1_FFFF_FFFD;
    #1;
    release dut33.uptime;
    bus_write(3'd5, 32'h1, 4'b0001);
    repeat (2) @(posedge clock);
    bus_read(3'd2, d, v, d3, v3);
    checks++;
    if (d3 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL lo_at_max: data=%h required FFFFFFFF", d3);
    end
    bus_read(3'd5, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h5) begin
      errors++;
      $display("FAIL ctrl_ovf: data=%h required 00000005", d3);
    end
    bus_read(3'd3, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h1) begin
      errors++;
      $display("FAIL hi33_snap: data=%h required 00000001", d3);
    end
    bus_read(3'd2, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h2) begin
      errors++;
      $display("FAIL lo_after_wrap: data=%h required 00000002", d3);
    end
    bus_write(3'd5, 32'h5, 4'b0001);
    bus_read(3'd5, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h1) begin
      errors++;
      $display("FAIL ovf_w1c: data=%h required 00000001", d3);
    end
    bus_write(3'd5, 32'h2, 4'b0001);
    repeat (10) @(posedge clock);
    bus_read(3'd2, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h0) begin
      errors++;
      $display("FAIL clear_halt: data=%h required 00000000", d3);
    end
    bus_read(3'd5, d, v, d3, v3);
    checks++;
    if (d3 !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_halted: data=%h required 00000000", d3);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d, d3; logic v, v3;
    bus_write(3'd4, 32'h11223344, 4'b1111);
    @(negedge clock);
    address = 3'd4; read = 1'b1;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rdv64 !== 1'b0 || rd64 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h required 0/0", rdv64, rd64);
    end
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (rdv64 !== 1'b0) begin
      errors++;
      $display("FAIL stale_strobe: valid=%b required 0", rdv64);
    end
    bus_read(3'd4, d, v, d3, v3);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL scratch_rst: data=%h valid=%b required 0/1", d, v);
    end
    bus_read(3'd5, d, v, d3, v3);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_rst: data=%h required 00000001", d);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    test_id_caps();
    test_scratch();
    test_hi_snapshot();
    test_wrap33();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
